// File: rtl/stream_merge2.sv
// stream_merge2: merges two valid/ready streams into one registered output stream.
// A round-robin arbiter picks between A and B on contention. Each output beat is
// tagged with its source index (0 = A, 1 = B) so a downstream demux can split it again.
module stream_merge2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             resetN,

    input  logic [WIDTH-1:0] inDataA,
    input  logic             inValidA,
    output logic             inReadyA,

    input  logic [WIDTH-1:0] inDataB,
    input  logic             inValidB,
    output logic             inReadyB,

    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    output logic             outSelect,
    input  logic             outReady
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_sel_q,   out_sel_d;
    // Source of the most recently accepted beat; reset to B so A wins first.
    logic             last_sel_q,  last_sel_d;

    logic can_load;
    logic grant_a;
    logic grant_b;
    logic accept_a;
    logic accept_b;

    // Arbitration and readies: depend only on valids, outReady and state, never on data.
    always_comb begin
        can_load = !out_valid_q || outReady;
        grant_a  = resetN && inValidA && (!inValidB || last_sel_q);
        grant_b  = resetN && inValidB && (!inValidA || !last_sel_q);
        inReadyA = can_load && grant_a;
        inReadyB = can_load && grant_b;
        accept_a = inReadyA && inValidA;
        accept_b = inReadyB && inValidB;
    end

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_sel_d  = last_sel_q;
        if (accept_a) begin
            out_valid_d = 1'b1;
            out_data_d  = inDataA;
            out_sel_d   = 1'b0;
            last_sel_d  = 1'b0;
        end else if (accept_b) begin
            out_valid_d = 1'b1;
            out_data_d  = inDataB;
            out_sel_d   = 1'b1;
            last_sel_d  = 1'b1;
        end else if (out_valid_q && outReady) begin
            // Drain without refill: data and tag are kept, only valid drops.
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
            last_sel_q  <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_sel_q  <= last_sel_d;
        end
    end

    // Output register drives the consumer side directly.
    always_comb begin
        outValid  = out_valid_q;
        outData   = out_data_q;
        outSelect = out_sel_q;
    end

endmodule
